// File: rtl/fb_addr_gen.sv
// Frame-buffer read-address generator: raster (hcount, vcount) -> BRAM address,
// with power-of-two decimation, window clipping and tear-free bank swapping.
module fb_addr_gen #(
  parameter int HCOUNT_W  = 11,
  parameter int VCOUNT_W  = 10,
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int SHIFT     = 1,
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 18,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [HCOUNT_W-1:0] hcount,
  input  logic [VCOUNT_W-1:0] vcount,
  input  logic                pix_valid_in,
  input  logic                swap_req,
  output logic [ADDR_W-1:0]   addr,
  output logic                addr_valid,
  output logic                in_window,
  output logic [BANK_W-1:0]   bank,
  output logic                swap_ack
);

  localparam logic [ADDR_W-1:0] FBW_A   = ADDR_W'(FB_WIDTH);
  localparam logic [ADDR_W-1:0] FRAME_A = ADDR_W'(FB_WIDTH * FB_HEIGHT);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  // All products are formed at full address width so no term is truncated early.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [BANK_W-1:0]   b,
                                                 input logic [VCOUNT_W-1:0] v,
                                                 input logic [HCOUNT_W-1:0] h);
    return ADDR_W'(b) * FRAME_A + ADDR_W'(v) * FBW_A + ADDR_W'(h);
  endfunction

  // Bank control state
  logic [BANK_W-1:0] bank_q, bank_d;
  logic              pending_q, pending_d;
  logic              fs, do_swap;

  // Stage-1 registers
  logic [HCOUNT_W-1:0] hs_p1_q, hs_d;
  logic [VCOUNT_W-1:0] vs_p1_q, vs_d;
  logic                win_p1_q, win_d;
  logic                vld_p1_q;
  logic                ack_p1_q;
  logic [BANK_W-1:0]   bank_p1_q;

  // Stage-2 (output) registers
  logic [ADDR_W-1:0] addr_q;
  logic              addr_valid_q;
  logic              in_window_q;
  logic [BANK_W-1:0] bank_out_q;
  logic              swap_ack_q;

  always_comb begin
    hs_d  = hcount >> SHIFT;
    vs_d  = vcount >> SHIFT;
    win_d = (int'(hs_d) < FB_WIDTH) && (int'(vs_d) < FB_HEIGHT);
    fs    = pix_valid_in && (hcount == '0) && (vcount == '0);
    // A swap requested in the very cycle of the frame start is honoured there.
    do_swap   = fs && (pending_q || swap_req);
    bank_d    = bank_q;
    pending_d = pending_q;
    if (do_swap) begin
      bank_d    = (bank_q == LAST_BANK) ? '0 : bank_q + 1'b1;
      pending_d = 1'b0;
    end else if (swap_req) begin
      pending_d = 1'b1;
    end
  end

  // ---- stage 1: decimate, clip, bank select ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q    <= '0;
      pending_q <= 1'b0;
      hs_p1_q   <= '0;
      vs_p1_q   <= '0;
      win_p1_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      ack_p1_q  <= 1'b0;
      bank_p1_q <= '0;
    end else begin
      bank_q    <= bank_d;
      pending_q <= pending_d;
      hs_p1_q   <= hs_d;
      vs_p1_q   <= vs_d;
      win_p1_q  <= win_d;
      vld_p1_q  <= pix_valid_in;
      ack_p1_q  <= do_swap;
      bank_p1_q <= bank_d;
    end
  end

  // ---- stage 2: linear address ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      in_window_q  <= 1'b0;
      bank_out_q   <= '0;
      swap_ack_q   <= 1'b0;
    end else begin
      addr_q       <= win_p1_q ? pix_addr(bank_p1_q, vs_p1_q, hs_p1_q) : '0;
      addr_valid_q <= vld_p1_q && win_p1_q;
      in_window_q  <= win_p1_q;
      bank_out_q   <= bank_p1_q;
      swap_ack_q   <= ack_p1_q;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign in_window  = in_window_q;
  assign bank       = bank_out_q;
  assign swap_ack   = swap_ack_q;

endmodule
